// File: rtl/i2c_register_reader_if.sv
// i2c_register_reader_if: user-side link between the register reader and i2c_controller
//   ack             controller -> reader  byte acknowledged by peripheral
//   nack            controller -> reader  byte not acknowledged
//   received_data   controller -> reader  last byte read from the bus
//   address         reader -> controller  7-bit peripheral address
//   read_write      reader -> controller  1 = read transaction
//   transmit_data   reader -> controller  next byte to write
//   enable_transfer reader -> controller  keep transaction running
interface i2c_register_reader_if;
   logic       ack;
   logic       nack;
   logic [7:0] received_data;
   logic [6:0] address;
   logic       read_write;
   logic [7:0] transmit_data;
   logic       enable_transfer;
   modport master (input ack, nack, received_data, output address, read_write, transmit_data, enable_transfer);
   modport slave (output ack, nack, received_data, input address, read_write, transmit_data, enable_transfer);
endinterface

// File: rtl/i2c_register_reader.sv
// i2c_register_reader: writes a 16-bit register pointer, then reads read_length bytes via i2c_controller
//   clk, reset        controller clock, synchronous active-high reset
//   start             request strobe, ignored while busy
//   register_address  pointer sent MSB first, latched on accepted start
//   read_length       bytes to read, 0 = pointer write only
//   busy/done/error   request status; error is valid with done and held until next start
//   data_out/data_valid/data_index  received byte stream
//   i2c               controller-side interface (master modport)
module i2c_register_reader #(
   parameter logic [6:0] DEVICE_ADDRESS = 7'h33,
   parameter int STOP_GAP = 8,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [15:0] register_address,
   input  logic [7:0] read_length,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic [7:0] data_index,
   i2c_register_reader_if.master i2c
);
   typedef enum logic [3:0] {IDLE, W_ADDR, W_HI, W_LO, GAP, R_ADDR, R_DATA, DRAIN, FINISH} state_t;
   localparam logic [7:0] GAP_LOAD = 8'(STOP_GAP);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   state_t state, state_n;
   logic [15:0] reg_q, reg_n, tmo, tmo_n;
   logic [7:0] len_q, len_n, count, count_n, gap, gap_n, data_out_n, data_index_n, tx_n;
   logic ack_q, nack_q, busy_n, done_n, error_n, valid_n, rw_n, en_n;
   logic ack_edge, nack_edge, on_bus;
   assign ack_edge = i2c.ack & ~ack_q;
   assign nack_edge = i2c.nack & ~nack_q;
   assign on_bus = state inside {W_ADDR, W_HI, W_LO, R_ADDR, R_DATA};
   assign i2c.address = DEVICE_ADDRESS;
   always_comb begin
      state_n = state;
      reg_n = reg_q;
      len_n = len_q;
      count_n = count;
      gap_n = gap;
      busy_n = busy;
      done_n = 1'b0;
      error_n = error;
      valid_n = 1'b0;
      data_out_n = data_out;
      data_index_n = data_index;
      rw_n = i2c.read_write;
      tx_n = i2c.transmit_data;
      en_n = i2c.enable_transfer;
      case (state)
         IDLE: if (start) begin
            reg_n = register_address;
            len_n = read_length;
            busy_n = 1'b1;
            error_n = 1'b0;
            rw_n = 1'b0;
            tx_n = register_address[15:8];
            en_n = 1'b1;
            state_n = W_ADDR;
         end
         W_ADDR: if (ack_edge) state_n = W_HI;
         // enable drops here so the controller treats the low byte as the last one
         W_HI: if (ack_edge) begin
            tx_n = reg_q[7:0];
            en_n = 1'b0;
            state_n = W_LO;
         end
         W_LO: if (ack_edge) begin
            gap_n = GAP_LOAD;
            state_n = GAP;
         end
         GAP: if (gap != 8'd0) gap_n = gap - 8'd1;
            else if (len_q == 8'd0) state_n = FINISH;
            else begin
               rw_n = 1'b1;
               en_n = 1'b1;
               state_n = R_ADDR;
            end
         R_ADDR: if (ack_edge) begin
            count_n = 8'd0;
            state_n = R_DATA;
         end
         R_DATA: if (ack_edge) begin
            data_out_n = i2c.received_data;
            data_index_n = count;
            valid_n = 1'b1;
            count_n = count + 8'd1;
            if (count + 8'd1 == len_q) begin
               en_n = 1'b0;
               gap_n = GAP_LOAD;
               state_n = DRAIN;
            end
         end
         // the controller finishes its current byte and STOP while we wait here
         DRAIN: if (gap != 8'd0) gap_n = gap - 8'd1; else state_n = FINISH;
         FINISH: begin
            done_n = 1'b1;
            busy_n = 1'b0;
            rw_n = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
      if ((nack_edge && !(state inside {IDLE, FINISH})) || (on_bus && !ack_edge && tmo == TMO_LAST)) begin
         en_n = 1'b0;
         error_n = 1'b1;
         gap_n = GAP_LOAD;
         state_n = DRAIN;
      end
      tmo_n = (!on_bus || state_n != state || ack_edge) ? 16'd0 : tmo + 16'd1;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         reg_q <= '0;
         len_q <= '0;
         count <= '0;
         gap <= '0;
         tmo <= '0;
         ack_q <= 1'b0;
         nack_q <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         error <= 1'b0;
         data_valid <= 1'b0;
         data_out <= '0;
         data_index <= '0;
         i2c.read_write <= 1'b0;
         i2c.transmit_data <= '0;
         i2c.enable_transfer <= 1'b0;
      end else begin
         state <= state_n;
         reg_q <= reg_n;
         len_q <= len_n;
         count <= count_n;
         gap <= gap_n;
         tmo <= tmo_n;
         ack_q <= i2c.ack;
         nack_q <= i2c.nack;
         busy <= busy_n;
         done <= done_n;
         error <= error_n;
         data_valid <= valid_n;
         data_out <= data_out_n;
         data_index <= data_index_n;
         i2c.read_write <= rw_n;
         i2c.transmit_data <= tx_n;
         i2c.enable_transfer <= en_n;
      end
   end
endmodule

// File: tb/tb_i2c_register_reader.sv
// tb_i2c_register_reader: directed bench with a behavioural i2c_controller and request-level scoreboard
module tb_i2c_register_reader;
   localparam int BYTE_CYC = 6;
   localparam int STOP_GAP = 8;
   logic clk = 0, reset = 1, start = 0;
   logic [15:0] register_address = 0;
   logic [7:0] read_length = 0;
   logic busy, done, error, data_valid;
   logic [7:0] data_out, data_index;
   i2c_register_reader_if bus();
   i2c_register_reader dut (
      .clk(clk), .reset(reset), .start(start), .register_address(register_address),
      .read_length(read_length), .busy(busy), .done(done), .error(error), .data_out(data_out),
      .data_valid(data_valid), .data_index(data_index), .i2c(bus)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_cmp = 0, n_bad = 0;
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // controller model: bytes take BYTE_CYC clocks, ack is a 2-clock pulse, enable is
   // sampled at the end of each byte to decide whether that byte is the last one
   bit nack_addr_write = 0, stall_read = 0;
   logic [7:0] rd_base = 0;
   int c_ph = 0, c_cnt = 0, c_bi = 0, n_wr_txn = 0, n_rd_txn = 0, last_wr_ack_cyc = 0;
   bit c_rw = 0, c_addr = 0, c_last = 0, c_nak = 0;
   logic [7:0] c_tx = 0;
   logic [7:0] wr_bytes[$];
   always @(posedge clk) begin
      if (reset) begin
         c_ph <= 0;
         c_cnt <= 0;
         bus.ack <= 1'b0;
         bus.nack <= 1'b0;
         bus.received_data <= 8'h00;
      end else case (c_ph)
         0: if (bus.enable_transfer) begin
            c_ph <= 1;
            c_cnt <= 0;
            c_rw <= bus.read_write;
            c_addr <= 1;
            c_bi <= 0;
            if (bus.read_write) n_rd_txn <= n_rd_txn + 1; else n_wr_txn <= n_wr_txn + 1;
         end
         1: if (c_cnt == BYTE_CYC - 1) begin
            c_last <= !bus.enable_transfer;
            c_cnt <= 0;
            if (c_addr && !c_rw && nack_addr_write) begin
               bus.nack <= 1'b1;
               c_nak <= 1;
               c_ph <= 2;
            end else if (!c_addr && c_rw && stall_read) c_ph <= 4;
            else begin
               bus.ack <= 1'b1;
               c_nak <= 0;
               c_ph <= 2;
               if (!c_addr && c_rw) begin
                  bus.received_data <= rd_base + 8'(c_bi);
                  c_bi <= c_bi + 1;
               end
               if (!c_addr && !c_rw) begin
                  wr_bytes.push_back(c_tx);
                  if (!bus.enable_transfer) last_wr_ack_cyc <= cyc;
               end
            end
         end else c_cnt <= c_cnt + 1;
         2: if (c_cnt == 1) begin
            bus.ack <= 1'b0;
            bus.nack <= 1'b0;
            c_cnt <= 0;
            c_addr <= 0;
            c_tx <= bus.transmit_data;
            c_ph <= (c_last || c_nak) ? 3 : 1;
         end else c_cnt <= c_cnt + 1;
         3: if (c_cnt == 2) begin
            c_ph <= 0;
            c_cnt <= 0;
         end else c_cnt <= c_cnt + 1;
         4: if (!bus.enable_transfer) begin
            c_ph <= 3;
            c_cnt <= 0;
         end
         default: c_ph <= 0;
      endcase
   end
   // scoreboard: byte k of a read must carry the model's k-th byte; done carries the expected status
   bit exp_err = 0;
   int exp_valids = 0, exp_idx = 0, n_done = 0;
   always @(negedge clk) if (!reset) begin
      chk("address", bus.address, 16'h33);
      if (start && !busy) exp_idx = 0;
      if (data_valid) begin
         chk("valid_busy", busy, 1);
         chk("data_index", data_index, 16'(exp_idx));
         chk("data_out", data_out, 16'(rd_base + 8'(exp_idx)));
         exp_idx++;
      end
      if (done) begin
         chk("done_error", error, exp_err);
         chk("valid_count", 16'(exp_idx), 16'(exp_valids));
         chk("busy_at_done", busy, 0);
         n_done++;
      end
   end
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic request(input logic [15:0] a, input logic [7:0] l);
      register_address = a;
      read_length = l;
      start = 1;
      tick();
      start = 0;
   endtask
   task automatic wait_done(input int lim, output int at);
      bit ok = 0;
      at = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            at = cyc;
         end
      end
      chk("done_seen", ok, 1);
      tick();
   endtask
   task automatic wait_idle();
      int n = 0;
      while (n < 300 && (c_ph != 0 || bus.enable_transfer)) begin
         @(negedge clk);
         n++;
      end
      chk("bus_idle", (c_ph == 0 && !bus.enable_transfer), 1);
      tick(2);
   endtask
   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_done"}, done, 0);
      chk({nm, "_error"}, error, 0);
      chk({nm, "_valid"}, data_valid, 0);
      chk({nm, "_data"}, data_out, 0);
      chk({nm, "_index"}, data_index, 0);
      chk({nm, "_enable"}, bus.enable_transfer, 0);
      chk({nm, "_rw"}, bus.read_write, 0);
      chk({nm, "_tx"}, bus.transmit_data, 0);
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int s_wr, s_rd, s_done, dc, sc, n;
      reset = 1;
      tick(2);
      @(negedge clk);
      chk_reset_outputs("rst");
      tick();
      reset = 0;
      tick(2);
      // 1: pointer 0x0400, two bytes; a second start while busy must be dropped
      s_wr = wr_bytes.size(); s_rd = n_rd_txn; s_done = n_done;
      rd_base = 8'hC0; exp_err = 0; exp_valids = 2;
      request(16'h0400, 8'd2);
      chk("t1_busy", busy, 1);
      tick(3);
      request(16'hFFFF, 8'd7);
      wait_done(600, dc);
      chk("t1_wr_count", 16'(wr_bytes.size() - s_wr), 2);
      chk("t1_tx_hi", wr_bytes[s_wr], 16'h04);
      chk("t1_tx_lo", wr_bytes[s_wr + 1], 16'h00);
      chk("t1_rd_txn", 16'(n_rd_txn - s_rd), 1);
      chk("t1_last_data", data_out, 16'hC1);
      chk("t1_last_index", data_index, 16'h01);
      chk("t1_error", error, 0);
      wait_idle();
      chk("t1_one_done", 16'(n_done - s_done), 1);
      // 2: pointer-only write
      s_wr = wr_bytes.size(); s_rd = n_rd_txn;
      rd_base = 8'h10; exp_err = 0; exp_valids = 0;
      request(16'h800D, 8'd0);
      wait_done(600, dc);
      chk("t2_tx_hi", wr_bytes[s_wr], 16'h80);
      chk("t2_tx_lo", wr_bytes[s_wr + 1], 16'h0D);
      chk("t2_no_read", 16'(n_rd_txn - s_rd), 0);
      chk("t2_gap", (dc - last_wr_ack_cyc) >= STOP_GAP, 1);
      wait_idle();
      chk("t2_still_no_read", 16'(n_rd_txn - s_rd), 0);
      // 3: address NACK during the write phase
      s_wr = wr_bytes.size(); s_rd = n_rd_txn;
      nack_addr_write = 1; exp_err = 1; exp_valids = 0;
      request(16'h1234, 8'd3);
      for (n = 0; n < 200 && !bus.nack; n++) @(negedge clk);
      chk("t3_nack_seen", bus.nack, 1);
      for (n = 0; n < 10 && bus.enable_transfer; n++) @(negedge clk);
      chk("t3_enable_drop", n <= 2, 1);
      wait_done(600, dc);
      chk("t3_error", error, 1);
      chk("t3_no_write_bytes", 16'(wr_bytes.size() - s_wr), 0);
      nack_addr_write = 0;
      wait_idle();
      chk("t3_no_read", 16'(n_rd_txn - s_rd), 0);
      chk("t3_error_held", error, 1);
      // 4: controller stalls on the first data byte
      s_rd = n_rd_txn;
      stall_read = 1; exp_err = 1; exp_valids = 0; rd_base = 8'h20;
      sc = cyc;
      request(16'h0020, 8'd4);
      chk("t4_error_cleared", error, 0);
      wait_done(6000, dc);
      chk("t4_error", error, 1);
      chk("t4_timeout_len", (dc - sc) >= 4096, 1);
      chk("t4_rd_txn", 16'(n_rd_txn - s_rd), 1);
      stall_read = 0;
      wait_idle();
      // 5: single-byte read
      rd_base = 8'h7E; exp_err = 0; exp_valids = 1;
      request(16'h0100, 8'd1);
      for (n = 0; n < 300 && !data_valid; n++) @(negedge clk);
      chk("t5_valid_seen", data_valid, 1);
      for (n = 0; n < 10 && bus.enable_transfer; n++) @(negedge clk);
      chk("t5_enable_drop", n <= 1, 1);
      wait_done(600, dc);
      chk("t5_data", data_out, 16'h7E);
      chk("t5_index", data_index, 16'h00);
      chk("t5_error", error, 0);
      wait_idle();
      // 6: reset while receiving, then a clean request
      rd_base = 8'h30; exp_err = 0; exp_valids = 4;
      request(16'h00AA, 8'd4);
      for (n = 0; n < 300 && !data_valid; n++) @(negedge clk);
      chk("t6_valid_seen", data_valid, 1);
      tick();
      reset = 1;
      tick();
      @(negedge clk);
      chk_reset_outputs("t6");
      tick();
      reset = 0;
      tick(2);
      rd_base = 8'h55; exp_err = 0; exp_valids = 3;
      request(16'h0102, 8'd3);
      wait_done(600, dc);
      chk("t6_data", data_out, 16'h57);
      chk("t6_index", data_index, 16'h02);
      chk("t6_error", error, 0);
      wait_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
